regfile_mp: RTL

//  Parametrised multi-read-port register file for the KGP RISC datapath; successor to the 2-read/1-write 32x32 file.

---
 rtl/regfile_mp_pkg.sv | 13 +
 rtl/regfile_clear_seq.sv | 64 ++++++
 rtl/regfile_mp.sv | 81 ++++++++
 3 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared types and default geometry for the multi-port register file.
package regfile_mp_pkg;

  typedef enum logic {
    RF_CLEAR,
    RF_RUN
  } rf_state_t;

  localparam int unsigned RF_DATA_W = 32;
  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned RF_NREAD  = 2;

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: sweeps every register to zero after reset or a clr request,
// then raises ready. Drives the clear write port of the storage array.
module regfile_clear_seq
  import regfile_mp_pkg::*;
#(
  parameter int unsigned ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              ready,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST = '1;

  rf_state_t         state, state_n;
  logic [ADDR_W-1:0] ptr, ptr_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RF_CLEAR;
      ptr   <= '0;
      ready <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      ready <= (state_n == RF_RUN);
    end
  end

  // A clr seen mid-sweep restarts the pointer so a full sweep always follows it.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    case (state)
      RF_CLEAR: begin
        if (clr) begin
          ptr_n = '0;
        end else if (ptr == LAST) begin
          state_n = RF_RUN;
          ptr_n   = '0;
        end else begin
          ptr_n = ptr + 1'b1;
        end
      end
      RF_RUN: begin
        if (clr) begin
          state_n = RF_CLEAR;
          ptr_n   = '0;
        end
      end
      default: begin
        state_n = RF_CLEAR;
        ptr_n   = '0;
      end
    endcase
  end

  assign clr_we   = (state == RF_CLEAR);
  assign clr_addr = ptr;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with clear engine and dropped-write flag.
// Optional write-to-read forwarding when REGFILE_MP_BYPASS_EN is defined.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned ADDR_W   = RF_ADDR_W,
  parameter int unsigned NREAD    = RF_NREAD,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  output logic                    ready,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       waddr,
  input  logic [DATA_W-1:0]       wdata,
  output logic                    wr_drop,
  input  logic [NREAD*ADDR_W-1:0] raddr,
  output logic [NREAD*DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              host_wr;

  regfile_clear_seq #(.ADDR_W(ADDR_W)) u_clear_seq (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .ready    (ready),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign host_wr = ready && we && !clr && !((ZERO_REG != 0) && (waddr == '0));

  // Storage is deliberately not reset; the sweep zeroes it instead.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (host_wr) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_drop <= 1'b0;
    end else begin
      wr_drop <= we && (!ready || clr);
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              zr;
    logic [DATA_W-1:0] rd;

    assign ra = raddr[i*ADDR_W +: ADDR_W];
    assign zr = (ZERO_REG != 0) && (ra == '0);

    always_comb begin
      rd = mem[ra];
`ifdef REGFILE_MP_BYPASS_EN
      if (ready && we && !clr && (ra == waddr) && !zr) begin
        rd = wdata;
      end
`endif
      if (!ready || zr) begin
        rd = '0;
      end
    end

    assign rdata[i*DATA_W +: DATA_W] = rd;
  end

endmodule
